// File: rtl/onehot_decoder_pipe.sv
// Pipelined binary-to-one-hot decoder with a two-entry skid buffer between a
// valid/ready code input and a valid/ready one-hot output, plus a saturating drain counter.
module onehot_decoder_pipe #(
    parameter int IN_W  = 4,
    parameter int CNT_W = 16,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_code,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_onehot,
    output logic [CNT_W-1:0] o_count,
    output logic [1:0]       o_state
);

    // Handshake rule for both ports: a word moves on a rising edge where
    // valid and ready are both high; the sender holds data stable while
    // valid is high and ready is low. Both ready and valid here are registered.

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] skid_q;
    logic [OUT_W-1:0] word_in;
    logic             accept;
    logic             drain;
    logic             load_out_new;
    logic             load_out_skid;
    logic             load_skid;
    logic             clear_out;

    assign accept  = i_valid & o_ready;
    assign drain   = o_valid & i_ready;
    assign word_in = i_enable ? (OUT_W'(1'b1) << i_code) : '0;

    always_comb begin
        state_nxt     = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        clear_out     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_ONE;
                    load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                case ({accept, drain})
                    2'b11: load_out_new = 1'b1;
                    2'b10: begin
                        state_nxt = ST_TWO;
                        load_skid = 1'b1;
                    end
                    2'b01: begin
                        state_nxt = ST_EMPTY;
                        clear_out = 1'b1;
                    end
                    default: state_nxt = ST_ONE;
                endcase
            end
            ST_TWO: begin
                // o_ready is low here, so only the drain side can move.
                if (drain) begin
                    state_nxt     = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
                clear_out = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
            o_count <= '0;
        end else begin
            state   <= state_nxt;
            o_valid <= (state_nxt != ST_EMPTY);
            o_ready <= (state_nxt != ST_TWO);
            if (load_out_new) begin
                out_q <= word_in;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end else if (clear_out) begin
                out_q <= '0;
            end
            if (load_skid) begin
                skid_q <= word_in;
            end
            if (drain && (o_count != {CNT_W{1'b1}})) begin
                o_count <= o_count + 1'b1;
            end
        end
    end

    assign o_onehot = out_q;
    assign o_state  = state;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: a FIFO-queue reference model checked every
// cycle, directed scenarios with literal expectations, and randomized traffic.
module tb_onehot_decoder_pipe;

    logic        clk;
    logic        rst_n;
    logic        i_enable;
    logic        i_valid;
    logic [3:0]  i_code;
    logic        i_ready;

    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_onehot;
    logic [15:0] o_count;
    logic [1:0]  o_state;

    logic        o_ready4;
    logic        o_valid4;
    logic [15:0] o_onehot4;
    logic [3:0]  o_count4;
    logic [1:0]  o_state4;

    onehot_decoder_pipe #(.IN_W(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(i_enable), .i_valid(i_valid),
        .o_ready(o_ready), .i_code(i_code), .o_valid(o_valid), .i_ready(i_ready),
        .o_onehot(o_onehot), .o_count(o_count), .o_state(o_state)
    );

    onehot_decoder_pipe #(.IN_W(4), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(i_enable), .i_valid(i_valid),
        .o_ready(o_ready4), .i_code(i_code), .o_valid(o_valid4), .i_ready(i_ready),
        .o_onehot(o_onehot4), .o_count(o_count4), .o_state(o_state4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: words in flight, total drains, predicted ready
    logic [15:0] exp_q[$];
    int          drains;
    logic        mdl_ready;
    logic        last_acc;
    int          pass_cnt;
    int          chk_cnt;

    function automatic logic [15:0] decode_word(input logic [3:0] c, input logic en);
        logic [15:0] w;
        w = '0;
        if (en) w[c] = 1'b1;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_cycle();
        logic        ev;
        logic [15:0] eoh;
        ev  = (exp_q.size() > 0);
        eoh = ev ? exp_q[0] : 16'h0000;
        check("valid", 32'(o_valid), 32'(ev));
        check("ready", 32'(o_ready), 32'(mdl_ready));
        check("onehot", 32'(o_onehot), 32'(eoh));
        check("count", 32'(o_count), (drains > 65535) ? 32'd65535 : 32'(drains));
        check("onehot_prop", 32'($countones(o_onehot) <= 1), 32'd1);
        check("valid4", 32'(o_valid4), 32'(ev));
        check("onehot4", 32'(o_onehot4), 32'(eoh));
        check("count4", 32'(o_count4), (drains > 15) ? 32'd15 : 32'(drains));
    endtask

    // driver: check the outputs settled from the last edge, then drive this cycle
    task automatic step(input logic v, input logic [3:0] c, input logic en, input logic rdy);
        logic acc;
        logic drn;
        @(negedge clk);
        check_cycle();
        i_valid  = v;
        i_code   = v ? c : 4'bxxxx;
        i_enable = en;
        i_ready  = rdy;
        acc = v && mdl_ready;
        drn = (exp_q.size() > 0) && rdy;
        if (drn) begin
            void'(exp_q.pop_front());
            drains++;
        end
        if (acc) exp_q.push_back(decode_word(c, en));
        mdl_ready = (exp_q.size() < 2);
        last_acc  = acc;
    endtask

    initial begin
        int          accepted;
        int          guard;
        logic        hold;
        logic        v;
        logic [3:0]  c;
        logic        en;
        logic        rdy;

        pass_cnt  = 0;
        chk_cnt   = 0;
        drains    = 0;
        mdl_ready = 1'b1;
        last_acc  = 1'b0;
        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_code    = 4'd0;
        i_enable  = 1'b1;
        i_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);
        rst_n = 1'b1;

        // test 1: codes 0..15 streamed with no backpressure
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 4'(k), 1'b1, 1'b1);
            if (k == 4) check("t1_latency", 32'(o_onehot), 32'h0008);
        end
        step(1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        check("t1_count16", 32'(o_count), 32'd16);
        check("t1_idle", 32'(o_valid), 32'd0);

        // test 2: disabled decode still delivers a word
        step(1'b1, 4'd5, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        check("t2_valid", 32'(o_valid), 32'd1);
        check("t2_zero", 32'(o_onehot), 32'h0000);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        check("t2_count17", 32'(o_count), 32'd17);

        // test 3: backpressure fills the skid buffer
        step(1'b1, 4'd3, 1'b1, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        check("t3_ready_low", 32'(o_ready), 32'd0);
        check("t3_hold", 32'(o_onehot), 32'h0008);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        check("t3_first", 32'(o_onehot), 32'h0008);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        check("t3_second", 32'(o_onehot), 32'h0080);
        check("t3_ready_back", 32'(o_ready), 32'd1);
        step(1'b0, 4'd0, 1'b1, 1'b1);

        // test 4: random codes with random backpressure
        accepted = 0;
        guard    = 0;
        hold     = 1'b0;
        c        = 4'd0;
        en       = 1'b1;
        while (accepted < 1000 && guard < 20000) begin
            if (!hold) begin
                v  = ($urandom_range(0, 3) != 0);
                c  = 4'($urandom_range(0, 15));
                en = ($urandom_range(0, 9) != 0);
            end else begin
                v = 1'b1;
            end
            rdy = ($urandom_range(0, 2) != 0);
            step(v, c, en, rdy);
            if (last_acc) accepted++;
            hold = v && !last_acc;
            guard++;
        end
        check("t4_budget", 32'(accepted), 32'd1000);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            step(1'b0, 4'd0, 1'b1, 1'b1);
            guard++;
        end
        step(1'b0, 4'd0, 1'b1, 1'b1);

        // test 5: narrow counter saturates
        check("t5_sat", 32'(o_count4), 32'hF);

        // test 6: asynchronous reset while two words are held
        step(1'b1, 4'd1, 1'b1, 1'b0);
        step(1'b1, 4'd2, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        check("t6_in_two", 32'(o_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(o_valid), 32'd0);
        check("t6_onehot", 32'(o_onehot), 32'h0000);
        check("t6_count", 32'(o_count), 32'd0);
        check("t6_count4", 32'(o_count4), 32'd0);
        exp_q.delete();
        drains    = 0;
        mdl_ready = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'd0, 1'b1, 1'b1);
        check("t6_ready_after", 32'(o_ready), 32'd1);
        step(1'b1, 4'd9, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        check("t6_resume", 32'(o_onehot), 32'h0200);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
